kbd_host_tx: RTL

Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It drives the open-drain ps2clk and ps2data lines through output-enable signals and runs the full request-to-send sequence, including the device acknowledge. It sits beside the PS/2 scancode receiver on the same two lines; the receiver must ignore traffic while tx_busy is high.

---
 rtl/kbd_host_tx_pkg.sv | 38 +++
 rtl/ps2_edge_sync.sv | 23 ++
 rtl/kbd_host_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/kbd_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
// Holds the FSM state encoding, common keyboard command bytes, edge-count milestones
// and the odd-parity helper.
package kbd_host_tx_pkg;

  // State encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_RTS     = 3'd2;
  localparam logic [2:0] ST_BITS    = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    INHIBIT = ST_INHIBIT,
    RTS     = ST_RTS,
    BITS    = ST_BITS,
    ACK     = ST_ACK,
    DONE    = ST_DONE
  } tx_state_t;

  // Common keyboard commands
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Device clock falling-edge milestones within a frame
  localparam logic [3:0] LAST_DATA_EDGE = 4'd8;
  localparam logic [3:0] PARITY_EDGE    = 4'd9;
  localparam logic [3:0] STOP_EDGE      = 4'd10;

  // Odd parity: the 9 transmitted bits carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Purpose: filter the raw PS/2 clock line and flag each falling edge.
// Latency: the edge flag fires 4 cycles after the first low sample.
// Backpressure: none; the flag is a single-cycle pulse per edge.
// Ports: clk, reset (async, active-high), line_in (raw line), fall (edge pulse).
module ps2_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic fall
);

  logic [7:0] history;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) history <= 8'h00;
    else       history <= {history[6:0], line_in};
  end

  // Four stable highs followed by four stable lows; this pattern holds for
  // exactly one cycle, so it doubles as glitch filter and one-shot.
  assign fall = (history[7:4] == 4'hF) && (history[3:0] == 4'h0);

endmodule

// File: rtl/kbd_host_tx.sv
// Purpose: PS/2 host-to-device byte transmitter (inhibit, request-to-send, 8 data bits,
//          odd parity, stop bit, device ACK) driving open-drain lines via output enables.
// Latency: INHIBIT_CYCLES + 1 RTS cycle + 11 device clock edges + 1 DONE cycle.
// Backpressure: tx_start is only accepted in IDLE; requests while busy are dropped.
// Ports: clk, reset (async, active-high), ps2clk_in/ps2data_in (raw lines),
//        ps2clk_oe/ps2data_oe (1 = pull low), tx_data/tx_start (request),
//        tx_busy, tx_done (pulse), tx_ack_ok, tx_error (valid with tx_done).
// Optional: define KBD_TX_TIMEOUT_EN to abort when the device clock stalls for
//           TIMEOUT_CYCLES while the frame is in flight.
module kbd_host_tx
  import kbd_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

  tx_state_t        state;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       edge_cnt;
  logic [3:0]       edge_next;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             clk_fall;
  logic             tmo_hit;

  ps2_edge_sync u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2clk_in),
    .fall    (clk_fall)
  );

  assign edge_next = edge_cnt + 4'd1;

`ifdef KBD_TX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts idle cycles between device edges; cleared in RTS so it starts
  // from zero on entry to BITS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              tmo_cnt <= '0;
    else if (state == RTS || clk_fall)      tmo_cnt <= '0;
    else if (state == BITS || state == ACK) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == BITS || state == ACK) && !clk_fall &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_ack_ok  <= 1'b0;
      tx_error   <= 1'b0;
      inh_cnt    <= '0;
      edge_cnt   <= 4'd0;
      data_q     <= 8'h00;
      parity_q   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            data_q    <= tx_data;
            parity_q  <= odd_parity(tx_data);
            inh_cnt   <= '0;
            ps2clk_oe <= 1'b1;
            tx_busy   <= 1'b1;
            state     <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2data_oe <= 1'b1;  // start bit, held through the first device edge
            state      <= RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        RTS: begin
          ps2clk_oe <= 1'b0;  // hand the clock to the device
          edge_cnt  <= 4'd0;
          state     <= BITS;
        end
        BITS: begin
          if (tmo_hit) begin
            ps2data_oe <= 1'b0;
            tx_ack_ok  <= 1'b0;
            tx_error   <= 1'b1;
            tx_done    <= 1'b1;
            state      <= DONE;
          end else if (clk_fall) begin
            edge_cnt <= edge_next;
            if (edge_next <= LAST_DATA_EDGE) begin
              ps2data_oe <= ~data_q[3'(edge_next - 4'd1)];
            end else if (edge_next == PARITY_EDGE) begin
              ps2data_oe <= ~parity_q;
            end else if (edge_next == STOP_EDGE) begin
              ps2data_oe <= 1'b0;  // released line floats high as the stop bit
              state      <= ACK;
            end
          end
        end
        ACK: begin
          if (tmo_hit) begin
            tx_ack_ok <= 1'b0;
            tx_error  <= 1'b1;
            tx_done   <= 1'b1;
            state     <= DONE;
          end else if (clk_fall) begin
            tx_ack_ok <= ~ps2data_in;
            tx_error  <= 1'b0;
            tx_done   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
